// File: rtl/trainer_session_ctrl.sv
// Session sequencer for the cycle trainer: start/stop button, profile fetch,
// periodic temperature sampling with request time-outs and an error state.
module trainer_session_ctrl #(
    parameter int ADC_W         = 12,
    parameter int CNT_W         = 16,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int TIMEOUT       = 255
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             button,
    input  logic             db_ack,
    input  logic             adc_valid,
    input  logic [ADC_W-1:0] adc_data,
    output logic             db_req,
    output logic             sensor_req,
    output logic [ADC_W-1:0] sample,
    output logic             sample_valid,
    output logic [CNT_W-1:0] sample_count,
    output logic             active,
    output logic [1:0]       err
);

    localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DB   = 2'b01;
    localparam logic [1:0] ERR_ADC  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DB_REQ,
        S_SENSE,
        S_WAIT,
        S_ERROR
    } state_e;

    state_e           state_q, state_d;
    logic             button_q;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic             db_req_q, db_req_d;
    logic             sensor_req_q, sensor_req_d;
    logic [ADC_W-1:0] sample_q, sample_d;
    logic             sample_valid_q, sample_valid_d;
    logic [CNT_W-1:0] sample_count_q, sample_count_d;
    logic             active_q, active_d;
    logic [1:0]       err_q, err_d;

    logic press;
    logic expire;
    logic tmr_zero;
    logic capture;
    logic start;

    assign press    = button & ~button_q;
    assign expire   = (to_cnt_q == TO_LAST);
    assign tmr_zero = (tmr_q == '0);
    assign capture  = (state_q == S_SENSE) && adc_valid;
    assign start    = (state_q == S_IDLE) && press;

    // State register and every output flop
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q        <= S_IDLE;
            button_q       <= 1'b0;
            tmr_q          <= '0;
            to_cnt_q       <= '0;
            db_req_q       <= 1'b0;
            sensor_req_q   <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
            sample_count_q <= '0;
            active_q       <= 1'b0;
            err_q          <= ERR_NONE;
        end else begin
            state_q        <= state_d;
            button_q       <= button;
            tmr_q          <= tmr_d;
            to_cnt_q       <= to_cnt_d;
            db_req_q       <= db_req_d;
            sensor_req_q   <= sensor_req_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
            sample_count_q <= sample_count_d;
            active_q       <= active_d;
            err_q          <= err_d;
        end
    end

    // Priority: stop press, then the acknowledge, then time-out expiry
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (press) state_d = S_DB_REQ;
            end
            S_DB_REQ: begin
                if (press)       state_d = S_IDLE;
                else if (db_ack) state_d = S_SENSE;
                else if (expire) state_d = S_ERROR;
            end
            S_SENSE: begin
                if (press)          state_d = S_IDLE;
                else if (adc_valid) state_d = S_WAIT;
                else if (expire)    state_d = S_ERROR;
            end
            S_WAIT: begin
                if (press)         state_d = S_IDLE;
                else if (tmr_zero) state_d = S_SENSE;
            end
            S_ERROR: begin
                if (press) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        db_req_d       = (state_d == S_DB_REQ);
        sensor_req_d   = (state_d == S_SENSE);
        active_d       = (state_d == S_DB_REQ) ||
                         (state_d == S_SENSE)  ||
                         (state_d == S_WAIT);
        sample_valid_d = capture;
        sample_d       = sample_q;
        sample_count_d = sample_count_q;
        err_d          = err_q;
        tmr_d          = tmr_q;
        to_cnt_d       = '0;

        if (start) sample_count_d = '0;
        if (capture) begin
            sample_d = adc_data;
            if (sample_count_q != CNT_MAX)
                sample_count_d = sample_count_q + 1'b1;
        end

        // Outstanding-request age restarts on every entry to a request state
        if ((state_d == state_q) &&
            ((state_q == S_DB_REQ) || (state_q == S_SENSE)))
            to_cnt_d = to_cnt_q + 1'b1;

        if (capture)
            tmr_d = TMR_LOAD;
        else if ((state_q == S_WAIT) && !tmr_zero)
            tmr_d = tmr_q - 1'b1;

        if (start || ((state_q == S_ERROR) && press))
            err_d = ERR_NONE;
        else if (state_d == S_ERROR && state_q == S_DB_REQ)
            err_d = ERR_DB;
        else if (state_d == S_ERROR && state_q == S_SENSE)
            err_d = ERR_ADC;
    end

    assign db_req       = db_req_q;
    assign sensor_req   = sensor_req_q;
    assign sample       = sample_q;
    assign sample_valid = sample_valid_q;
    assign sample_count = sample_count_q;
    assign active       = active_q;
    assign err          = err_q;

endmodule

// File: tb/tb_trainer_session_ctrl.sv
// Randomized scoreboard bench for trainer_session_ctrl against a
// session-level reference model (small CNT_W/SAMPLE_PERIOD/TIMEOUT).
module tb_trainer_session_ctrl;

    localparam int ADC_W = 12;
    localparam int CNT_W = 4;
    localparam int SP    = 4;
    localparam int TO    = 8;

    logic             clock = 1'b0;
    logic             rst = 1'b1;
    logic             button = 1'b0;
    logic             db_ack = 1'b0;
    logic             adc_valid = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             db_req;
    logic             sensor_req;
    logic [ADC_W-1:0] sample;
    logic             sample_valid;
    logic [CNT_W-1:0] sample_count;
    logic             active;
    logic [1:0]       err;

    trainer_session_ctrl #(
        .ADC_W(ADC_W),
        .CNT_W(CNT_W),
        .SAMPLE_PERIOD(SP),
        .TIMEOUT(TO)
    ) dut (
        .clock(clock),
        .rst(rst),
        .button(button),
        .db_ack(db_ack),
        .adc_valid(adc_valid),
        .adc_data(adc_data),
        .db_req(db_req),
        .sensor_req(sensor_req),
        .sample(sample),
        .sample_valid(sample_valid),
        .sample_count(sample_count),
        .active(active),
        .err(err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic             db_req;
        logic             sensor_req;
        logic             active;
        logic             sample_valid;
        logic [1:0]       err;
        logic [CNT_W-1:0] count;
        logic [ADC_W-1:0] sample;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;

    // Reference model: session phase plus plain integer ages
    typedef enum int {IDLE, FETCH, SENSING, PAUSE, FAULT} phase_e;
    phase_e     m_phase = IDLE;
    int         m_age = 0;
    int         m_gap = 0;
    int         m_cnt = 0;
    int         m_err = 0;
    int         m_smp = 0;
    bit         m_sv = 0;
    bit         m_prev = 0;

    task automatic model_step(input bit r, input bit b, input bit ack,
                              input bit av, input int d);
        bit pr;
        if (r) begin
            m_phase = IDLE; m_age = 0; m_gap = 0; m_cnt = 0;
            m_err = 0; m_smp = 0; m_sv = 0; m_prev = 0;
            return;
        end
        pr = b && !m_prev;
        m_prev = b;
        m_sv = 0;
        case (m_phase)
            IDLE: if (pr) begin
                m_phase = FETCH; m_age = 0; m_cnt = 0; m_err = 0;
            end
            FETCH: begin
                if (pr) m_phase = IDLE;
                else if (ack) begin m_phase = SENSING; m_age = 0; end
                else begin
                    m_age++;
                    if (m_age >= TO) begin m_phase = FAULT; m_err = 1; end
                end
            end
            SENSING: begin
                if (av) begin
                    m_smp = d; m_sv = 1;
                    if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                    m_gap = 0;
                    m_phase = pr ? IDLE : PAUSE;
                end else if (pr) m_phase = IDLE;
                else begin
                    m_age++;
                    if (m_age >= TO) begin m_phase = FAULT; m_err = 2; end
                end
            end
            PAUSE: begin
                if (pr) m_phase = IDLE;
                else begin
                    m_gap++;
                    if (m_gap >= SP) begin m_phase = SENSING; m_age = 0; end
                end
            end
            FAULT: if (pr) begin m_phase = IDLE; m_err = 0; end
            default: m_phase = IDLE;
        endcase
    endtask

    function automatic obs_t model_out();
        obs_t o;
        o.db_req       = (m_phase == FETCH);
        o.sensor_req   = (m_phase == SENSING);
        o.active       = (m_phase == FETCH) || (m_phase == SENSING) ||
                         (m_phase == PAUSE);
        o.sample_valid = m_sv;
        o.err          = m_err[1:0];
        o.count        = m_cnt[CNT_W-1:0];
        o.sample       = m_smp[ADC_W-1:0];
        return o;
    endfunction

    // Monitor: one expected output vector per clock edge
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = '{db_req, sensor_req, active, sample_valid,
                      err, sample_count, sample};
                checks++;
                if (a === e) passed++;
                else $display("FAIL cyc %0d outputs: got req=%b/%b act=%b sv=%b err=%b cnt=%0d smp=%h, exp req=%b/%b act=%b sv=%b err=%b cnt=%0d smp=%h",
                    cyc, a.db_req, a.sensor_req, a.active, a.sample_valid,
                    a.err, a.count, a.sample, e.db_req, e.sensor_req,
                    e.active, e.sample_valid, e.err, e.count, e.sample);
            end
        end
    end

    task automatic drive(input bit r, input bit b, input bit ack,
                         input bit av, input int d);
        @(negedge clock);
        rst = r; button = b; db_ack = ack; adc_valid = av;
        adc_data = d[ADC_W-1:0];
        model_step(r, b, ack, av, d);
        exp_q.push_back(model_out());
    endtask

    int seg_len [6] = '{300, 400, 400, 400, 300, 200};
    int btn_pm  [6] = '{ 60,  40,   3,  30, 100,   0};
    int ack_pct [6] = '{ 30,   5,  60,  40,  90,  50};
    int adc_pct [6] = '{ 30,   5,  70,  40,  90,  50};
    int rst_pm  [6] = '{  0,   0,   0,  10,   2,   0};

    initial begin
        bit b;
        b = 0;
        repeat (3) drive(1, 0, 0, 0, 0);
        for (int s = 0; s < 6; s++) begin
            for (int i = 0; i < seg_len[s]; i++) begin
                bit r, ack, av;
                if ($urandom_range(999) < btn_pm[s]) b = ~b;
                // last segment: button held high for 50 cycles mid-session
                if (s == 5) b = (i >= 20 && i < 70) || (i >= 150);
                r   = ($urandom_range(999) < rst_pm[s]);
                ack = ($urandom_range(99) < ack_pct[s]);
                av  = ($urandom_range(99) < adc_pct[s]);
                drive(r, b, ack, av, int'($urandom_range(4095)));
            end
        end
        drive(0, b, 0, 0, 0);
        repeat (3) @(negedge clock);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/trainer_session_ctrl.md
Name: trainer_session_ctrl

Overview:
Session sequencer for the cycle trainer. A button press opens a session, and the block then requests the user profile from the database interface. It next runs periodic temperature acquisitions on the ADC/sensor path, handing each captured sample downstream to the temperature conversion and LED logic. A second button press closes the session, and request time-outs force an error state.

Parameters:
ADC_W, 12, width of adc_data and sample
CNT_W, 16, width of sample_count
SAMPLE_PERIOD, 1000, clock cycles from the end of one sample to the next sensor_req (must be ≥1)
TIMEOUT, 255, maximum cycles a request may stay outstanding without acknowledge (must be ≥1)

Ports:
clock  in  1  system clock; the block's only clock
rst  in  1  synchronous reset, active-high
button  in  1  start/stop push button, level, already debounced; rising edge detected internally
db_ack  in  1  database interface: profile received, single-cycle pulse
adc_valid  in  1  sensor path: adc_data valid this cycle
adc_data  in  ADC_W  raw ADC reading
db_req  out  1  database request, held until db_ack or abort
sensor_req  out  1  sensor request, held until adc_valid or abort
sample  out  ADC_W  last captured ADC reading
sample_valid  out  1  one-cycle strobe: sample updated
sample_count  out  CNT_W  samples captured this session, saturating
active  out  1  session running (any state except IDLE, ERROR)
err  out  2  00 none, 01 database timeout, 10 sensor timeout

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; every output 0.
  - button edge register=0, interval timer=0, timeout counter=0.
  - Reset takes effect mid-session and drops requests on that same edge.
- Edge detection: press = button & ~button_q. button_q is registered every cycle. A held button produces exactly one press.
- All outputs are registered (Moore). Each state transition takes effect at the clock edge where its condition is sampled.
- IDLE:
  - On press, go to DB_REQ, set db_req=1 and active=1, and clear sample_count and err.
  - The cycle after button is first sampled high, db_req is seen high.
- DB_REQ:
  - On db_ack, go to SENSE: db_req=0, sensor_req=1, timeout counter cleared.
  - Timeout counter increments each cycle that db_req=1. When it reaches TIMEOUT without db_ack, go to ERROR with err=01.
  - If db_ack arrives on the same cycle the count reaches TIMEOUT, db_ack wins.
- SENSE:
  - On adc_valid: sample<=adc_data, sample_valid=1 for exactly one cycle, sample_count+1 (holds at 2^CNT_W-1), sensor_req=0. Load the interval timer with SAMPLE_PERIOD-1 and go to WAIT.
  - Timeout works as in DB_REQ; on expiry go to ERROR with err=10. adc_valid wins a tie with expiry.
- WAIT:
  - Interval timer decrements each cycle. At 0, go to SENSE with sensor_req=1 and the timeout counter cleared.
  - With SAMPLE_PERIOD=1, sensor_req reasserts on the cycle after sample_valid.
- Stop: a press in DB_REQ, SENSE or WAIT goes to IDLE.
  - db_req, sensor_req and active go to 0 on that edge.
  - sample and sample_count are retained until the next start.
- Simultaneous events:
  - press plus adc_valid in SENSE: the sample is captured and counted (sample_valid=1), then IDLE.
  - press plus db_ack in DB_REQ: IDLE, no sensor_req.
  - press on the cycle a timeout expires: stop wins, err stays 00.
- ERROR:
  - active=0 and both requests are 0; err holds.
  - A press goes to IDLE and clears err. It does not start a session; a further press is required.
- Ignored inputs:
  - db_ack outside DB_REQ and adc_valid outside SENSE are ignored; no state or output changes.
  - sample_valid is never asserted outside the SENSE→WAIT/IDLE transition.

Test Plan:
- Reset, then press at cycle 10; db_ack at 15; adc_valid at 20 with adc_data=0x3A7 → db_req 11–15, sensor_req 16–20, sample=0x3A7, sample_valid only at 21, sample_count=1, active=1.
- SAMPLE_PERIOD=4: run 3 samples with adc_valid 2 cycles after each sensor_req → sensor_req rises exactly 4 cycles after each sample_valid; sample_count=3.
- TIMEOUT=8, no db_ack → err=01 and active=0 after 8 cycles of db_req. Repeat in SENSE → err=10. A press clears err, and a second press restarts the session with sample_count=0.
- Press coincident with adc_valid → sample captured, sample_count incremented, same edge enters IDLE, sensor_req=0. Button held 50 cycles → only one press.
- CNT_W=4: 17 samples → sample_count saturates at 15. rst asserted mid-WAIT → all outputs 0 on the next edge.
- db_ack/adc_valid pulses while IDLE or WAIT → no output change.
